piso_frame_serializer: RTL and testbench

- Parallel-in/serial-out framer that sits directly upstream of the serial sequence-detector FSMs.
- Accepts a WIDTH-bit word through a load/ready handshake. Emits it one bit per clock on x, with a bit_valid qualifier and a last-bit marker.
- Inserts a programmable idle gap between frames. Counts completed frames so the detector's output can be correlated against frames.

---
 rtl/piso_frame_serializer.sv | 142 ++++++++++++++
 tb/tb_piso_frame_serializer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/piso_frame_serializer.sv
// piso_frame_serializer
//   Parallel-in / serial-out framer feeding the serial sequence detectors.
//   A WIDTH-bit word is accepted on a load/ready handshake and sent one bit
//   per clock on x. bit_valid qualifies each frame bit and last marks the
//   final bit. GAP idle cycles follow each frame. Completed frames are
//   counted modulo 256.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   load       accept request, honoured only on an edge where ready=1
//   data       word to serialize, captured on the accepting edge
//   ready      a word can be accepted at the next posedge
//   x          serial bit stream, 0 when idle
//   bit_valid  x carries a frame bit this cycle
//   last       x is the final bit of the frame
//   frame_cnt  completed-frame count, wraps 255 -> 0
module piso_frame_serializer #(
  parameter int WIDTH     = 8,   // 2..16
  parameter int GAP       = 1,   // 0..15
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             x,
  output logic             bit_valid,
  output logic             last,
  output logic [7:0]       frame_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // Counter reload values; the GAP reload is never used when GAP=0 but must
  // still be a legal 4-bit constant.
  localparam logic [3:0] BCNT_INIT = 4'(WIDTH - 1);
  localparam logic [3:0] GCNT_INIT = 4'((GAP > 0) ? (GAP - 1) : 0);
  localparam bit         HAS_GAP   = (GAP > 0);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt, sreg_adv;
  logic [3:0]       bcnt, bcnt_nxt;
  logic [3:0]       gcnt, gcnt_nxt;
  logic [7:0]       fcnt_nxt;
  logic             bit_last;

  // The outgoing bit always sits at the same end of the shift register, so
  // advancing just drops it and pulls a zero in from the far end.
  always_comb begin
    if (MSB_FIRST) sreg_adv = {sreg[WIDTH-2:0], 1'b0};
    else           sreg_adv = {1'b0, sreg[WIDTH-1:1]};
  end

  assign bit_last = (state == S_SHIFT) && (bcnt == 4'd0);

  // ---------------------------------------------------------------------------
  // State register and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      sreg      <= '0;
      bcnt      <= 4'd0;
      gcnt      <= 4'd0;
      frame_cnt <= 8'd0;
    end else begin
      state     <= state_nxt;
      sreg      <= sreg_nxt;
      bcnt      <= bcnt_nxt;
      gcnt      <= gcnt_nxt;
      frame_cnt <= fcnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath update
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    bcnt_nxt  = bcnt;
    gcnt_nxt  = gcnt;
    fcnt_nxt  = frame_cnt;
    case (state)
      S_IDLE: begin
        if (load) begin
          state_nxt = S_SHIFT;
          sreg_nxt  = data;
          bcnt_nxt  = BCNT_INIT;
        end
      end
      S_SHIFT: begin
        if (bcnt == 4'd0) begin
          fcnt_nxt = frame_cnt + 8'd1;
          if (HAS_GAP) begin
            state_nxt = S_GAP;
            gcnt_nxt  = GCNT_INIT;
            sreg_nxt  = '0;
          end else if (load) begin
            // Back-to-back: next word captured on the last-bit edge so
            // bit_valid never drops between frames.
            state_nxt = S_SHIFT;
            sreg_nxt  = data;
            bcnt_nxt  = BCNT_INIT;
          end else begin
            state_nxt = S_IDLE;
            sreg_nxt  = '0;
          end
        end else begin
          sreg_nxt = sreg_adv;
          bcnt_nxt = bcnt - 4'd1;
        end
      end
      S_GAP: begin
        // Entered with GAP-1, so the gap spans exactly GAP cycles.
        if (gcnt == 4'd0) state_nxt = S_IDLE;
        else              gcnt_nxt  = gcnt - 4'd1;
      end
      default: begin
        state_nxt = S_IDLE;
        sreg_nxt  = '0;
        bcnt_nxt  = 4'd0;
        gcnt_nxt  = 4'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: functions of registered state only, no path from load.
  // ---------------------------------------------------------------------------
  assign bit_valid = (state == S_SHIFT);
  assign last      = bit_last;
  assign x         = bit_valid && (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]);
  assign ready     = (state == S_IDLE) || (bit_last && !HAS_GAP);

endmodule

// File: tb/tb_piso_frame_serializer.sv
module tb_piso_frame_serializer;

  logic       clk;
  logic       reset;
  logic       load0, load1;
  logic [7:0] data0, data1;
  logic       ready0, x0, bv0, last0;
  logic       ready1, x1, bv1, last1;
  logic [7:0] fcnt0, fcnt1;

  int n_cmp = 0;
  int n_err = 0;

  // Defaults: WIDTH=8, GAP=1, MSB first
  piso_frame_serializer u0 (
    .clk(clk), .reset(reset), .load(load0), .data(data0),
    .ready(ready0), .x(x0), .bit_valid(bv0), .last(last0), .frame_cnt(fcnt0)
  );

  // Streaming instance: no gap, LSB first
  piso_frame_serializer #(.WIDTH(8), .GAP(0), .MSB_FIRST(1'b0)) u1 (
    .clk(clk), .reset(reset), .load(load1), .data(data1),
    .ready(ready1), .x(x1), .bit_valid(bv1), .last(last1), .frame_cnt(fcnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  w;
    logic [15:0] s;
    int          gaps;

    load0 = 0; data0 = 8'h00; load1 = 0; data1 = 8'h00;

    // ---- 1: reset state, then idle after release
    reset = 0;
    #3;
    chk("rst_x",     x0,     0);
    chk("rst_bv",    bv0,    0);
    chk("rst_last",  last0,  0);
    chk("rst_ready", ready0, 1);
    chk("rst_fcnt",  fcnt0,  0);
    chk("rst_fcnt1", fcnt1,  0);
    #9 reset = 1;
    gaps = 0;
    repeat (10) begin
      tick();
      if (x0 || bv0 || last0 || !ready0 || x1 || bv1) gaps++;
    end
    chk("idle_10cyc", gaps, 0);

    // ---- 2: single frame 8'b1000_1000, MSB first, one gap cycle
    w = 8'h88;
    load0 = 1; data0 = w;
    tick();
    load0 = 0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("f88_x%0d", i),    x0,    w[7-i]);
      chk($sformatf("f88_bv%0d", i),   bv0,   1);
      chk($sformatf("f88_last%0d", i), last0, (i == 7));
      chk($sformatf("f88_rdy%0d", i),  ready0, 0);
      tick();
    end
    chk("f88_fcnt",    fcnt0,  1);
    chk("f88_gap_rdy", ready0, 0);
    chk("f88_gap_x",   x0,     0);
    chk("f88_gap_bv",  bv0,    0);
    tick();
    chk("f88_idle_rdy", ready0, 1);

    // ---- 3: load pulse mid-frame is ignored
    w = 8'h5A;
    load0 = 1; data0 = w;
    tick();
    load0 = 0; data0 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("f5a_x%0d", i), x0, w[7-i]);
      if (i == 2) begin
        load0 = 1; data0 = 8'hFF;
      end
      tick();
      load0 = 0;
    end
    gaps = 0;
    repeat (6) begin
      tick();
      if (bv0) gaps++;
    end
    chk("f5a_no_extra", gaps, 0);
    chk("f5a_fcnt", fcnt0, 2);

    // ---- 4: GAP=0 LSB first back-to-back 01 then 80
    s = 16'h8001;
    load1 = 1; data1 = 8'h01;
    tick();
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("b2b_x%0d", i),    x1,    s[i]);
      chk($sformatf("b2b_bv%0d", i),   bv1,   1);
      chk($sformatf("b2b_last%0d", i), last1, (i == 7 || i == 15));
      if (i == 3) chk("b2b_rdy_mid", ready1, 0);
      if (i == 7) begin
        chk("b2b_rdy_last", ready1, 1);
        data1 = 8'h80;
      end
      if (i == 15) load1 = 0;
      tick();
    end
    chk("b2b_fcnt", fcnt1, 2);
    chk("b2b_end_bv", bv1, 0);

    // ---- 5: reset mid-frame, then fresh frame A5
    load0 = 1; data0 = 8'hC3;
    tick();
    load0 = 0;
    repeat (3) tick();
    chk("mid_bv_before", bv0, 1);
    reset = 0;
    #1;
    chk("mid_rst_x",    x0,     0);
    chk("mid_rst_bv",   bv0,    0);
    chk("mid_rst_rdy",  ready0, 1);
    chk("mid_rst_fcnt", fcnt0,  0);
    tick();
    tick();
    reset = 1;
    tick();
    chk("mid_post_bv", bv0, 0);
    w = 8'hA5;
    load0 = 1; data0 = w;
    tick();
    load0 = 0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("fa5_x%0d", i), x0, w[7-i]);
      tick();
    end
    chk("fa5_fcnt", fcnt0, 1);

    // ---- 6: 256 back-to-back frames, frame_cnt wrap
    load1 = 1; data1 = 8'h3C;
    tick();
    gaps = 0;
    for (int f = 1; f <= 256; f++) begin
      for (int b = 0; b < 8; b++) begin
        if (!bv1) gaps++;
        if (f == 256 && b == 7) load1 = 0;
        tick();
      end
      if (f == 255) chk("wrap_255", fcnt1, 255);
    end
    chk("wrap_0", fcnt1, 0);
    chk("stream_contig", gaps, 0);
    chk("stream_end_bv", bv1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
